// File: rtl/data_mem_responder.sv
// Word-addressed data memory behind a valid/ready request/response handshake.
// Responses arrive a fixed LATENCY cycles after accept and are held until consumed.
module data_mem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);
  localparam logic [2:0]  LAT_M1  = 3'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_r;
  logic [2:0]      cnt_r;
  logic            we_r;
  logic [AW-1:0]   idx_r;
  logic [31:0]     wdata_r;
  logic            err_r;
  logic            req_ready_r;
  logic            resp_valid_r;
  logic [31:0]     resp_rdata_r;
  logic            resp_err_r;
  logic [31:0]     mem_r [DEPTH];

  logic            accept_s;
  logic            addr_err_s;
  logic            fire_s;
  logic            commit_s;

  // req_ready_r mirrors "state is IDLE", so it doubles as the accept qualifier
  assign accept_s   = req_valid && req_ready_r;
  assign addr_err_s = (req_addr[1:0] != 2'b00) || ({2'b00, req_addr[31:2]} >= DEPTH_W);
  assign fire_s     = (state_r == WAIT) && (cnt_r == 3'd0);
  assign commit_s   = fire_s && we_r && !err_r && !reset;

  // Control FSM, latency counter, captured request and registered response
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      cnt_r        <= 3'd0;
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 32'd0;
      resp_err_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_r     <= WAIT;
            cnt_r       <= LAT_M1;
            req_ready_r <= 1'b0;
            we_r        <= req_we;
            idx_r       <= req_addr[AW+1:2];
            wdata_r     <= req_wdata;
            err_r       <= addr_err_s;
          end
        end
        WAIT: begin
          if (fire_s) begin
            state_r      <= RESP;
            resp_valid_r <= 1'b1;
            resp_err_r   <= err_r;
            resp_rdata_r <= (err_r || we_r) ? 32'd0 : mem_r[idx_r];
          end else begin
            cnt_r <= cnt_r - 3'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state_r      <= IDLE;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 32'd0;
            resp_err_r   <= 1'b0;
          end
        end
        default: begin
          state_r      <= IDLE;
          cnt_r        <= 3'd0;
          req_ready_r  <= 1'b1;
          resp_valid_r <= 1'b0;
          resp_rdata_r <= 32'd0;
          resp_err_r   <= 1'b0;
        end
      endcase
    end
  end

  // Storage array: no reset so contents survive a reset pulse
  always_ff @(posedge clk) begin
    if (commit_s) begin
      mem_r[idx_r] <= wdata_r;
    end
  end

  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_rdata = resp_rdata_r;
  assign resp_err   = resp_err_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed scenarios plus random traffic checked
// against an array-based memory model; a second instance runs with LATENCY=1.
module tb_data_mem_responder;

  localparam int DEPTH = 64;
  localparam int LAT_A = 2;
  localparam int LAT_B = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        a_req_valid = 1'b0;
  logic        a_req_ready;
  logic        a_req_we = 1'b0;
  logic [31:0] a_req_addr = 32'd0;
  logic [31:0] a_req_wdata = 32'd0;
  logic        a_resp_valid;
  logic        a_resp_ready = 1'b0;
  logic [31:0] a_resp_rdata;
  logic        a_resp_err;

  logic        b_req_valid = 1'b0;
  logic        b_req_ready;
  logic        b_req_we = 1'b0;
  logic [31:0] b_req_addr = 32'd0;
  logic [31:0] b_req_wdata = 32'd0;
  logic        b_resp_valid;
  logic        b_resp_ready = 1'b1;
  logic [31:0] b_resp_rdata;
  logic        b_resp_err;

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] mem_a [DEPTH];
  bit          known_a [DEPTH];
  logic [31:0] mem_b [DEPTH];

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT_A)) u_dut_a (
    .clk(clk), .reset(reset),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
    .resp_rdata(a_resp_rdata), .resp_err(a_resp_err)
  );

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT_B)) u_dut_b (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
  );

  always #5 clk = ~clk;

  function automatic bit addr_bad(input logic [31:0] addr);
    return ((addr % 32'd4) != 32'd0) || ((addr / 32'd4) >= 32'(DEPTH));
  endfunction

  function automatic int word_of(input logic [31:0] addr);
    return int'(addr / 32'd4);
  endfunction

  // Present one request on instance A and return just after its accept edge
  task automatic a_issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    int w = 0;
    @(negedge clk);
    while (!a_req_ready && w < 30) begin
      @(negedge clk);
      w++;
    end
    if (!a_req_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL issue_timeout req_ready=%0b required 1", a_req_ready);
    end
    a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr; a_req_wdata = wdata;
    @(posedge clk);
    #1;
    a_req_valid = 1'b0;
    a_req_we    = 1'($urandom);
    a_req_addr  = $urandom;
    a_req_wdata = $urandom;
  endtask

  // Count edges after the accept edge until resp_valid is seen (30 = gave up)
  task automatic a_wait_resp(output int lat);
    lat = 0;
    @(negedge clk);
    while (!a_resp_valid && lat < 30) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic a_consume;
    a_resp_ready = 1'b1;
    @(posedge clk);
    #1;
    a_resp_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (a_resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid got=%b exp=0", a_resp_valid); end
    n_cmp++; if (a_resp_rdata !== 32'd0) begin n_fail++; $display("FAIL rst_resp_rdata got=%h exp=0", a_resp_rdata); end
    n_cmp++; if (a_resp_err !== 1'b0) begin n_fail++; $display("FAIL rst_resp_err got=%b exp=0", a_resp_err); end
    n_cmp++; if (b_resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_b_resp_valid got=%b exp=0", b_resp_valid); end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (a_req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready got=%b exp=1", a_req_ready); end
    n_cmp++; if (b_req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_b_req_ready got=%b exp=1", b_req_ready); end
  endtask

  task automatic test_store_load;
    int lat;
    a_issue(1'b1, 32'h10, 32'hDEADBEEF);
    a_wait_resp(lat);
    n_cmp++; if (lat != LAT_A) begin n_fail++; $display("FAIL st_latency got=%0d exp=%0d", lat, LAT_A); end
    n_cmp++; if (a_resp_err !== 1'b0) begin n_fail++; $display("FAIL st_err got=%b exp=0", a_resp_err); end
    n_cmp++; if (a_resp_rdata !== 32'd0) begin n_fail++; $display("FAIL st_rdata got=%h exp=0", a_resp_rdata); end
    mem_a[4] = 32'hDEADBEEF; known_a[4] = 1'b1;
    a_consume;
    n_cmp++; if (a_req_ready !== 1'b1) begin n_fail++; $display("FAIL st_req_ready_after got=%b exp=1", a_req_ready); end
    n_cmp++; if (a_resp_valid !== 1'b0) begin n_fail++; $display("FAIL st_resp_drop got=%b exp=0", a_resp_valid); end
    a_issue(1'b0, 32'h10, $urandom);
    a_wait_resp(lat);
    n_cmp++; if (lat != LAT_A) begin n_fail++; $display("FAIL ld_latency got=%0d exp=%0d", lat, LAT_A); end
    n_cmp++; if (a_resp_rdata !== mem_a[4]) begin n_fail++; $display("FAIL ld_rdata got=%h exp=%h", a_resp_rdata, mem_a[4]); end
    n_cmp++; if (a_resp_err !== 1'b0) begin n_fail++; $display("FAIL ld_err got=%b exp=0", a_resp_err); end
    a_consume;
  endtask

  task automatic test_misaligned;
    int lat;
    a_issue(1'b1, 32'h13, 32'h12345678);
    a_wait_resp(lat);
    n_cmp++; if (a_resp_err !== 1'b1) begin n_fail++; $display("FAIL mis_err got=%b exp=1", a_resp_err); end
    n_cmp++; if (a_resp_rdata !== 32'd0) begin n_fail++; $display("FAIL mis_rdata got=%h exp=0", a_resp_rdata); end
    a_consume;
    a_issue(1'b0, 32'h10, 32'd0);
    a_wait_resp(lat);
    n_cmp++; if (a_resp_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL mis_keep got=%h exp=deadbeef", a_resp_rdata); end
    a_consume;
  endtask

  task automatic test_out_of_range;
    int lat;
    a_issue(1'b0, 32'h100, 32'd0);
    a_wait_resp(lat);
    n_cmp++; if (lat != LAT_A) begin n_fail++; $display("FAIL oor_latency got=%0d exp=%0d", lat, LAT_A); end
    n_cmp++; if (a_resp_err !== 1'b1) begin n_fail++; $display("FAIL oor_err got=%b exp=1", a_resp_err); end
    n_cmp++; if (a_resp_rdata !== 32'd0) begin n_fail++; $display("FAIL oor_rdata got=%h exp=0", a_resp_rdata); end
    a_consume;
  endtask

  task automatic test_backpressure;
    int lat;
    logic [31:0] rd0;
    logic er0;
    a_issue(1'b0, 32'h10, 32'd0);
    a_wait_resp(lat);
    rd0 = a_resp_rdata; er0 = a_resp_err;
    n_cmp++; if (rd0 !== mem_a[4]) begin n_fail++; $display("FAIL bp_rdata got=%h exp=%h", rd0, mem_a[4]); end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (a_resp_valid !== 1'b1 || a_resp_rdata !== rd0 || a_resp_err !== er0 || a_req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold cycle=%0d got v=%b d=%h e=%b rdy=%b exp v=1 d=%h e=%b rdy=0",
                 c, a_resp_valid, a_resp_rdata, a_resp_err, a_req_ready, rd0, er0);
      end
    end
    a_consume;
    n_cmp++; if (a_resp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drop got=%b exp=0", a_resp_valid); end
    n_cmp++; if (a_req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready got=%b exp=1", a_req_ready); end
  endtask

  task automatic test_reset_mid;
    int lat;
    bit seen;
    a_issue(1'b1, 32'h20, 32'h11112222);
    a_wait_resp(lat);
    mem_a[8] = 32'h11112222; known_a[8] = 1'b1;
    a_consume;
    // reset while the store is still waiting: no commit, no response
    a_issue(1'b1, 32'h20, 32'hCAFEF00D);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (a_resp_valid) seen = 1'b1;
      @(negedge clk);
    end
    n_cmp++; if (seen) begin n_fail++; $display("FAIL rstw_no_resp got=1 exp=0"); end
    n_cmp++; if (a_req_ready !== 1'b1) begin n_fail++; $display("FAIL rstw_ready got=%b exp=1", a_req_ready); end
    a_issue(1'b0, 32'h20, 32'd0);
    a_wait_resp(lat);
    n_cmp++; if (a_resp_rdata !== mem_a[8]) begin n_fail++; $display("FAIL rstw_old got=%h exp=%h", a_resp_rdata, mem_a[8]); end
    // reset while a response is held discards it
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n_cmp++; if (a_resp_valid !== 1'b0 || a_resp_rdata !== 32'd0) begin
      n_fail++; $display("FAIL rstr_discard got v=%b d=%h exp v=0 d=0", a_resp_valid, a_resp_rdata);
    end
    n_cmp++; if (a_req_ready !== 1'b1) begin n_fail++; $display("FAIL rstr_ready got=%b exp=1", a_req_ready); end
  endtask

  task automatic test_random;
    int lat, sel, hold, w;
    logic we, exp_err;
    logic [31:0] addr, data, exp_rd;
    for (int t = 0; t < 40; t++) begin
      sel  = $urandom_range(0, 9);
      we   = 1'($urandom_range(0, 1));
      data = $urandom;
      case (sel)
        7:       addr = 32'($urandom_range(0, DEPTH - 1)) * 32'd4 + 32'($urandom_range(1, 3));
        8:       addr = 32'($urandom_range(DEPTH, 1023)) * 32'd4;
        9:       addr = $urandom | 32'h8000_0000;
        default: addr = 32'($urandom_range(0, DEPTH - 1)) * 32'd4;
      endcase
      exp_err = addr_bad(addr);
      w = exp_err ? 0 : word_of(addr);
      if (!we && !exp_err && !known_a[w]) we = 1'b1;
      exp_rd = 32'd0;
      if (!we && !exp_err) exp_rd = mem_a[w];
      if (we && !exp_err) begin mem_a[w] = data; known_a[w] = 1'b1; end
      a_issue(we, addr, data);
      a_wait_resp(lat);
      n_cmp++; if (lat != LAT_A) begin n_fail++; $display("FAIL rnd_latency t=%0d got=%0d exp=%0d", t, lat, LAT_A); end
      n_cmp++; if (a_resp_err !== exp_err) begin n_fail++; $display("FAIL rnd_err t=%0d addr=%h got=%b exp=%b", t, addr, a_resp_err, exp_err); end
      hold = $urandom_range(0, 2);
      repeat (hold) begin @(posedge clk); @(negedge clk); end
      n_cmp++; if (a_resp_rdata !== exp_rd) begin n_fail++; $display("FAIL rnd_rdata t=%0d addr=%h got=%h exp=%h", t, addr, a_resp_rdata, exp_rd); end
      a_consume;
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] q_addr[$];
    logic        q_we[$];
    logic [31:0] q_data[$];
    logic [31:0] exp_rd[$];
    logic        exp_er[$];
    int          acc_edge[$];
    int cyc = 0, last_acc = -1, nresp = 0, k = 0, w;
    bit acc;
    logic [31:0] a;
    for (int i = 0; i < 4; i++) begin
      a = 32'(i * 16 + int'($urandom_range(0, 15))) * 32'd4;
      q_addr.push_back(a); q_we.push_back(1'b1); q_data.push_back($urandom);
    end
    for (int i = 3; i >= 0; i--) begin
      q_addr.push_back(q_addr[i]); q_we.push_back(1'b0); q_data.push_back($urandom);
    end
    @(negedge clk);
    b_req_valid = 1'b1; b_req_we = q_we[0]; b_req_addr = q_addr[0]; b_req_wdata = q_data[0];
    while (nresp < 8 && cyc < 200) begin
      if (b_resp_valid) begin
        n_cmp++;
        if (b_resp_rdata !== exp_rd[0] || b_resp_err !== exp_er[0]) begin
          n_fail++; $display("FAIL b2b_data n=%0d got d=%h e=%b exp d=%h e=%b", nresp, b_resp_rdata, b_resp_err, exp_rd[0], exp_er[0]);
        end
        n_cmp++;
        if (cyc - acc_edge[0] != LAT_B) begin
          n_fail++; $display("FAIL b2b_latency n=%0d got=%0d exp=%0d", nresp, cyc - acc_edge[0], LAT_B);
        end
        void'(exp_rd.pop_front()); void'(exp_er.pop_front()); void'(acc_edge.pop_front());
        nresp++;
      end
      acc = b_req_valid && b_req_ready;
      @(posedge clk);
      cyc++;
      if (acc) begin
        exp_er.push_back(addr_bad(q_addr[k]));
        w = word_of(q_addr[k]);
        if (q_we[k]) begin
          exp_rd.push_back(32'd0);
          mem_b[w] = q_data[k];
        end else begin
          exp_rd.push_back(mem_b[w]);
        end
        // accept edge, response edge, handshake edge, then the next accept
        if (last_acc >= 0) begin
          n_cmp++;
          if (cyc - last_acc != LAT_B + 2) begin
            n_fail++; $display("FAIL b2b_spacing k=%0d got=%0d exp=%0d", k, cyc - last_acc, LAT_B + 2);
          end
        end
        last_acc = cyc;
        acc_edge.push_back(cyc);
        k++;
        #1;
        if (k < 8) begin
          b_req_we = q_we[k]; b_req_addr = q_addr[k]; b_req_wdata = q_data[k];
        end else begin
          b_req_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    b_req_valid = 1'b0;
    n_cmp++; if (nresp != 8) begin n_fail++; $display("FAIL b2b_count got=%0d exp=8", nresp); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_misaligned();
    test_out_of_range();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
